// File: rtl/core_inst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_inst_pkg
// Description : Instruction-word field positions, IDLE word and sequencer
//               state encoding shared by the core instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package core_inst_pkg;

    localparam int INST_W     = 34;
    localparam int A_FIELD_W  = 11;

    localparam int B_ACC      = 33;
    localparam int B_CEN_P    = 32;
    localparam int B_WEN_P    = 31;
    localparam int B_AP_LSB   = 20;
    localparam int B_CEN_X    = 19;
    localparam int B_WEN_X    = 18;
    localparam int B_AX_LSB   = 7;
    localparam int B_OFIFO_RD = 6;
    localparam int B_SEL      = 4;
    localparam int B_L0_RD    = 3;
    localparam int B_L0_WR    = 2;
    localparam int B_EXEC     = 1;
    localparam int B_LOAD     = 0;

    // Both SRAMs deselected and write-disabled, everything else quiet.
    localparam logic [INST_W-1:0] IDLE_WORD = 34'h1800C0000;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WLD   = 4'd1,
        S_WPUSH = 4'd2,
        S_ALD   = 4'd3,
        S_EXEC  = 4'd4,
        S_DRAIN = 4'd5,
        S_NEXT  = 4'd6,
        S_FIN   = 4'd7,
        S_ERR   = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/core_inst_pack.sv
`default_nettype none
// ============================================================================
// Module      : core_inst_pack
// Description : Combinational assembly of the 34-bit core instruction word
//               from named fields.
// Revision    : 1.0 - initial release
// ============================================================================
module core_inst_pack
    import core_inst_pkg::*;
(
    input  logic                 acc,
    input  logic                 pmem_cen,
    input  logic                 pmem_wen,
    input  logic [A_FIELD_W-1:0] pmem_addr,
    input  logic                 xmem_cen,
    input  logic                 xmem_wen,
    input  logic [A_FIELD_W-1:0] xmem_addr,
    input  logic                 ofifo_rd,
    input  logic                 sel,
    input  logic                 l0_rd,
    input  logic                 l0_wr,
    input  logic                 execute,
    input  logic                 load,
    output logic [INST_W-1:0]    inst
);

    always_comb begin
        inst                           = '0;
        inst[B_ACC]                    = acc;
        inst[B_CEN_P]                  = pmem_cen;
        inst[B_WEN_P]                  = pmem_wen;
        inst[B_AP_LSB +: A_FIELD_W]    = pmem_addr;
        inst[B_CEN_X]                  = xmem_cen;
        inst[B_WEN_X]                  = xmem_wen;
        inst[B_AX_LSB +: A_FIELD_W]    = xmem_addr;
        inst[B_OFIFO_RD]               = ofifo_rd;
        inst[B_SEL]                    = sel;
        inst[B_L0_RD]                  = l0_rd;
        inst[B_L0_WR]                  = l0_wr;
        inst[B_EXEC]                   = execute;
        inst[B_LOAD]                   = load;
    end

endmodule
`default_nettype wire

// File: rtl/core_inst_seq.sv
`default_nettype none
// ============================================================================
// Module      : core_inst_seq
// Description : Walks every kernel position through weight load/push,
//               activation load, execute and psum drain, emitting a
//               registered core instruction word each cycle.
//               Optional drain watchdog: SEQ_DRAIN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_inst_seq
    import core_inst_pkg::*;
#(
    parameter int ROW    = 2,
    parameter int COL    = 2,
    parameter int ADDR_W = 11,
    parameter int KIJ_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [KIJ_W-1:0]  num_kij,
    input  logic [ADDR_W-1:0] num_nij,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              mode_in,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              mode,
    output logic              sel,
    output logic              busy,
`ifdef SEQ_DRAIN_TIMEOUT_EN
    output logic              err,
`endif
    output logic              done
);

    state_t              state_q, state_d;
    logic [KIJ_W-1:0]    k_q, k_d, kij_q, kij_d;
    logic [ADDR_W-1:0]   i_q, i_d, d_q, d_d;
    logic [ADDR_W-1:0]   nij_q, nij_d, w_base_q, w_base_d;
    logic [ADDR_W-1:0]   x_base_q, x_base_d, p_base_q, p_base_d;
    logic                sel_q, sel_d, busy_q, busy_d, done_q, done_d;
    logic                mode_q, mode_d, xrd_q, xrd_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [KIJ_W:0]      w_k_next;
    logic [ADDR_W-1:0]   w_waddr;
`ifdef SEQ_DRAIN_TIMEOUT_EN
    logic [7:0]          wd_q, wd_d;
    logic                err_q, err_d;
`endif

    logic                 w_acc, w_pcen, w_pwen, w_xcen, w_xwen;
    logic                 w_ofrd, w_sel, w_l0rd, w_l0wr, w_exec, w_load;
    logic [A_FIELD_W-1:0] w_paddr, w_xaddr;

    assign w_k_next = {1'b0, k_q} + (KIJ_W+1)'(1);
    assign w_waddr  = w_base_q + ADDR_W'(k_q) * ADDR_W'(ROW) + i_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        kij_d    = kij_q;
        i_d      = i_q;
        d_d      = d_q;
        nij_d    = nij_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mode_d   = mode_q;
        xrd_d    = 1'b0;
`ifdef SEQ_DRAIN_TIMEOUT_EN
        wd_d     = '0;
`endif
        w_acc    = 1'b0;
        w_pcen   = 1'b1;
        w_pwen   = 1'b1;
        w_paddr  = '0;
        w_xcen   = 1'b1;
        w_xwen   = 1'b1;
        w_xaddr  = '0;
        w_ofrd   = 1'b0;
        w_sel    = 1'b0;
        w_l0rd   = 1'b0;
        // L0 write trails each xmem read by one cycle (SRAM read latency)
        w_l0wr   = xrd_q;
        w_exec   = 1'b0;
        w_load   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kij_d    = num_kij;
                    nij_d    = num_nij;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    p_base_d = p_base;
                    mode_d   = mode_in;
                    k_d      = '0;
                    i_d      = '0;
                    d_d      = '0;
                    sel_d    = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = (num_kij == '0 || num_nij == '0) ? S_FIN : S_WLD;
                end
            end
            S_WLD: begin
                w_xcen  = 1'b0;
                w_xaddr = A_FIELD_W'(w_waddr);
                w_sel   = sel_q;
                xrd_d   = 1'b1;
                if (i_q == ADDR_W'(ROW - 1)) begin
                    i_d     = '0;
                    state_d = S_WPUSH;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_WPUSH: begin
                w_l0rd = 1'b1;
                w_load = 1'b1;
                w_sel  = sel_q;
                if (i_q == ADDR_W'(ROW + COL - 1)) begin
                    i_d     = '0;
                    state_d = S_ALD;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_ALD: begin
                w_xcen  = 1'b0;
                w_xaddr = A_FIELD_W'(x_base_q + i_q);
                w_sel   = sel_q;
                xrd_d   = 1'b1;
                if (i_q == nij_q - 1'b1) begin
                    i_d     = '0;
                    state_d = S_EXEC;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_EXEC: begin
                w_l0rd = 1'b1;
                w_exec = 1'b1;
                w_sel  = sel_q;
                if (i_q == nij_q - 1'b1) begin
                    i_d     = '0;
                    d_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_DRAIN: begin
                w_sel   = sel_q;
                w_paddr = inst_q[B_AP_LSB +: A_FIELD_W];
                if (d_q == nij_q) begin
                    state_d = S_NEXT;
                end else if (ofifo_valid) begin
                    w_ofrd  = 1'b1;
                    w_pcen  = 1'b0;
                    w_pwen  = 1'b0;
                    w_paddr = A_FIELD_W'(p_base_q + d_q);
                    w_acc   = (k_q != '0);
                    d_d     = d_q + 1'b1;
                end else begin
`ifdef SEQ_DRAIN_TIMEOUT_EN
                    wd_d = wd_q + 8'd1;
                    if (wd_d == 8'hFF) begin
                        state_d = S_ERR;
                    end
`endif
                end
            end
            S_NEXT: begin
                sel_d   = ~sel_q;
                k_d     = k_q + 1'b1;
                state_d = (w_k_next < {1'b0, kij_q}) ? S_WLD : S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
`ifdef SEQ_DRAIN_TIMEOUT_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SEQ_DRAIN_TIMEOUT_EN
        err_d = err_q | (state_d == S_ERR);
`endif
    end

    core_inst_pack u_pack (
        .acc       (w_acc),
        .pmem_cen  (w_pcen),
        .pmem_wen  (w_pwen),
        .pmem_addr (w_paddr),
        .xmem_cen  (w_xcen),
        .xmem_wen  (w_xwen),
        .xmem_addr (w_xaddr),
        .ofifo_rd  (w_ofrd),
        .sel       (w_sel),
        .l0_rd     (w_l0rd),
        .l0_wr     (w_l0wr),
        .execute   (w_exec),
        .load      (w_load),
        .inst      (inst_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            kij_q    <= '0;
            i_q      <= '0;
            d_q      <= '0;
            nij_q    <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            sel_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            xrd_q    <= 1'b0;
            inst_q   <= IDLE_WORD;
`ifdef SEQ_DRAIN_TIMEOUT_EN
            wd_q     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            kij_q    <= kij_d;
            i_q      <= i_d;
            d_q      <= d_d;
            nij_q    <= nij_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            p_base_q <= p_base_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            xrd_q    <= xrd_d;
            inst_q   <= inst_d;
`ifdef SEQ_DRAIN_TIMEOUT_EN
            wd_q     <= wd_d;
            err_q    <= err_d;
`endif
        end
    end

    assign inst = inst_q;
    assign mode = mode_q;
    assign sel  = sel_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SEQ_DRAIN_TIMEOUT_EN
    assign err  = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_inst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_inst_seq
// Description : Directed self-checking bench for the core instruction
//               sequencer (watchdog scenario under SEQ_DRAIN_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_inst_seq;

    localparam logic [33:0] C_IDLE = 34'h1800C0000;

    logic        clk = 1'b0;
    logic        reset, start, mode_in, ofifo_valid;
    logic [3:0]  num_kij;
    logic [10:0] num_nij, w_base, x_base, p_base;
    logic [33:0] inst;
    logic        mode, sel, busy, done;
`ifdef SEQ_DRAIN_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    logic [10:0] xa_q[$];
    logic [10:0] pa_q[$];
    bit          pacc_q[$];
    bit          psel_q[$];
    bit          pselp_q[$];
    int          load_n, exec_n, l0wr_n, ofrd_n, done_n, done_cyc, first_x_cyc;
    bit          busy_c1;
    bit          pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit          ofrd_log[8];

    core_inst_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_kij     (num_kij),
        .num_nij     (num_nij),
        .w_base      (w_base),
        .x_base      (x_base),
        .p_base      (p_base),
        .mode_in     (mode_in),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .mode        (mode),
        .sel         (sel),
        .busy        (busy),
`ifdef SEQ_DRAIN_TIMEOUT_EN
        .err         (err),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Launches one job and logs every instruction word until done (+2 cycles).
    task automatic run_job(input int kij, input int nij, input int wb, input int xb,
                           input int pb, input bit md, input bit pat_en, input int max_cyc);
        int pj;
        logic [33:0] w;
        xa_q.delete(); pa_q.delete(); pacc_q.delete(); psel_q.delete(); pselp_q.delete();
        load_n = 0; exec_n = 0; l0wr_n = 0; ofrd_n = 0; done_n = 0;
        done_cyc = -1; first_x_cyc = -1; pj = -1; busy_c1 = 1'b0;
        for (int j = 0; j < 8; j++) ofrd_log[j] = 1'b0;
        num_kij = 4'(kij); num_nij = 11'(nij);
        w_base = 11'(wb); x_base = 11'(xb); p_base = 11'(pb);
        mode_in = md; ofifo_valid = !pat_en; start = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            tick();
            start = 1'b0;
            if (c == 1) begin
                mode_in = !md;
                busy_c1 = busy;
            end
            w = inst;
            if (!w[19]) begin
                xa_q.push_back(w[17:7]);
                if (first_x_cyc < 0) first_x_cyc = c;
            end
            if (!w[32]) begin
                pa_q.push_back(w[30:20]);
                pacc_q.push_back(w[33]);
                psel_q.push_back(w[4]);
                pselp_q.push_back(sel);
            end
            load_n += int'(w[0]);
            exec_n += int'(w[1]);
            l0wr_n += int'(w[2]);
            ofrd_n += int'(w[6]);
            if (pat_en) begin
                if (pj >= 0) pj++;
                if (pj >= 1 && pj <= 7) ofrd_log[pj] = w[6];
                if (pj < 0 && exec_n == nij) pj = 0;
                ofifo_valid = (pj >= 0 && pj < 7) ? pat[pj] : 1'b0;
            end
            if (done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL job_timeout: no done within %0d cycles (required done pulse)", max_cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; num_kij = 4'd1; num_nij = 11'd4;
        w_base = '0; x_base = '0; p_base = '0; mode_in = 1'b1; ofifo_valid = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_busy: got %b want 0", busy); end
        reset = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (inst !== C_IDLE) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, C_IDLE); end
        checks++;
        if ({busy, done, sel, mode} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got busy/done/sel/mode=%b want 0000", {busy, done, sel, mode});
        end
    endtask

    task automatic test_single_kij;
        logic [10:0] ex[6] = '{11'd0, 11'd1, 11'd16, 11'd17, 11'd18, 11'd19};
        run_job(1, 4, 0, 16, 100, 1'b0, 1'b0, 100);
        checks++;
        if (xa_q.size() != 6) begin errors++; $display("FAIL single_xcount: got %0d want 6", xa_q.size()); end
        for (int j = 0; j < 6 && j < xa_q.size(); j++) begin
            checks++;
            if (xa_q[j] !== ex[j]) begin errors++; $display("FAIL single_xaddr[%0d]: got %0d want %0d", j, xa_q[j], ex[j]); end
        end
        checks++;
        if (pa_q.size() != 4) begin errors++; $display("FAIL single_pcount: got %0d want 4", pa_q.size()); end
        for (int j = 0; j < 4 && j < pa_q.size(); j++) begin
            checks++;
            if (pa_q[j] !== 11'(100 + j) || pacc_q[j] !== 1'b0 || psel_q[j] !== 1'b0) begin
                errors++; $display("FAIL single_pwrite[%0d]: got addr %0d acc %b sel %b want %0d 0 0",
                                   j, pa_q[j], pacc_q[j], psel_q[j], 100 + j);
            end
        end
        checks++;
        if (load_n != 4 || exec_n != 4 || l0wr_n != 6) begin
            errors++; $display("FAIL single_phases: got load %0d exec %0d l0wr %0d want 4 4 6", load_n, exec_n, l0wr_n);
        end
        checks++;
        if (first_x_cyc != 2) begin errors++; $display("FAIL single_first_read: got cycle %0d want 2", first_x_cyc); end
        checks++;
        if (done_cyc != 22 || done_n != 1) begin
            errors++; $display("FAIL single_done: got cycle %0d pulses %0d want 22 1", done_cyc, done_n);
        end
        checks++;
        if (busy !== 1'b0 || mode !== 1'b0) begin
            errors++; $display("FAIL single_end_flags: got busy %b mode %b want 0 0", busy, mode);
        end
    endtask

    task automatic test_multi_kij;
        logic [10:0] ex[12] = '{11'd0, 11'd1, 11'd16, 11'd17, 11'd2, 11'd3, 11'd16, 11'd17,
                                11'd4, 11'd5, 11'd16, 11'd17};
        bit ea[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bit es[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        run_job(3, 2, 0, 16, 100, 1'b0, 1'b0, 200);
        checks++;
        if (xa_q.size() != 12) begin errors++; $display("FAIL multi_xcount: got %0d want 12", xa_q.size()); end
        for (int j = 0; j < 12 && j < xa_q.size(); j++) begin
            checks++;
            if (xa_q[j] !== ex[j]) begin errors++; $display("FAIL multi_xaddr[%0d]: got %0d want %0d", j, xa_q[j], ex[j]); end
        end
        checks++;
        if (pa_q.size() != 6) begin errors++; $display("FAIL multi_pcount: got %0d want 6", pa_q.size()); end
        for (int j = 0; j < 6 && j < pa_q.size(); j++) begin
            checks++;
            if (pa_q[j] !== 11'(100 + (j % 2)) || pacc_q[j] !== ea[j] || psel_q[j] !== es[j] || pselp_q[j] !== es[j]) begin
                errors++; $display("FAIL multi_pwrite[%0d]: got addr %0d acc %b isel %b sel %b want %0d %b %b %b",
                                   j, pa_q[j], pacc_q[j], psel_q[j], pselp_q[j], 100 + (j % 2), ea[j], es[j], es[j]);
            end
        end
        checks++;
        if (done_n != 1) begin errors++; $display("FAIL multi_done: got %0d pulses want 1", done_n); end
    endtask

    task automatic test_drain_toggle;
        run_job(1, 4, 0, 16, 100, 1'b0, 1'b1, 100);
        for (int j = 1; j <= 7; j++) begin
            checks++;
            if (ofrd_log[j] !== pat[j-1]) begin
                errors++; $display("FAIL toggle_ofifo_rd[%0d]: got %b want %b", j, ofrd_log[j], pat[j-1]);
            end
        end
        checks++;
        if (ofrd_n != 4 || pa_q.size() != 4) begin
            errors++; $display("FAIL toggle_counts: got rd %0d writes %0d want 4 4", ofrd_n, pa_q.size());
        end
        for (int j = 0; j < 4 && j < pa_q.size(); j++) begin
            checks++;
            if (pa_q[j] !== 11'(100 + j)) begin errors++; $display("FAIL toggle_paddr[%0d]: got %0d want %0d", j, pa_q[j], 100 + j); end
        end
    endtask

    task automatic test_wrap;
        logic [10:0] ex[8] = '{11'd2046, 11'd2047, 11'd2047, 11'd0, 11'd0, 11'd1, 11'd2047, 11'd0};
        logic [10:0] ep[4] = '{11'd2047, 11'd0, 11'd2047, 11'd0};
        run_job(2, 2, 2046, 2047, 2047, 1'b1, 1'b0, 200);
        checks++;
        if (xa_q.size() != 8 || pa_q.size() != 4) begin
            errors++; $display("FAIL wrap_counts: got x %0d p %0d want 8 4", xa_q.size(), pa_q.size());
        end
        for (int j = 0; j < 8 && j < xa_q.size(); j++) begin
            checks++;
            if (xa_q[j] !== ex[j]) begin errors++; $display("FAIL wrap_xaddr[%0d]: got %0d want %0d", j, xa_q[j], ex[j]); end
        end
        for (int j = 0; j < 4 && j < pa_q.size(); j++) begin
            checks++;
            if (pa_q[j] !== ep[j]) begin errors++; $display("FAIL wrap_paddr[%0d]: got %0d want %0d", j, pa_q[j], ep[j]); end
        end
        checks++;
        if (mode !== 1'b1) begin errors++; $display("FAIL wrap_mode_latched: got %b want 1", mode); end
    endtask

    task automatic test_zero_nij;
        run_job(2, 0, 0, 16, 100, 1'b0, 1'b0, 20);
        checks++;
        if (done_cyc != 2 || done_n != 1 || busy_c1 !== 1'b1) begin
            errors++; $display("FAIL zero_done: got cycle %0d pulses %0d busy1 %b want 2 1 1", done_cyc, done_n, busy_c1);
        end
        checks++;
        if (xa_q.size() != 0 || pa_q.size() != 0) begin
            errors++; $display("FAIL zero_access: got x %0d p %0d want 0 0", xa_q.size(), pa_q.size());
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        int dn = 0;
        num_kij = 4'd1; num_nij = 11'd4; w_base = '0; x_base = 11'd16; p_base = 11'd100;
        ofifo_valid = 1'b1; start = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            start = 1'b0;
            if (inst[1]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_exec_timeout: execute never seen (want within 40)"); end
        reset = 1'b1;
        tick();
        checks++;
        if (inst !== C_IDLE || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got inst %h busy %b done %b want %h 0 0", inst, busy, done, C_IDLE);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            dn += int'(done);
        end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses want 0", dn); end
        run_job(1, 4, 0, 16, 100, 1'b0, 1'b0, 100);
        checks++;
        if (done_n != 1 || pa_q.size() != 4 || done_cyc != 22) begin
            errors++; $display("FAIL mid_rerun: got pulses %0d writes %0d cycle %0d want 1 4 22", done_n, pa_q.size(), done_cyc);
        end
    endtask

`ifdef SEQ_DRAIN_TIMEOUT_EN
    task automatic test_timeout;
        bit hit = 1'b0;
        num_kij = 4'd1; num_nij = 11'd2; w_base = '0; x_base = 11'd16; p_base = 11'd100;
        ofifo_valid = 1'b0; start = 1'b1;
        for (int c = 0; c < 400 && !hit; c++) begin
            tick();
            start = 1'b0;
            if (err) hit = 1'b1;
        end
        checks++;
        if (!hit || busy !== 1'b1) begin errors++; $display("FAIL timeout_err: got err %b busy %b want 1 1", err, busy); end
        tick();
        checks++;
        if (inst !== C_IDLE || err !== 1'b1) begin errors++; $display("FAIL timeout_hold: got inst %h err %b want %h 1", inst, err, C_IDLE); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ofifo_valid = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_kij();
        test_multi_kij();
        test_drain_toggle();
        test_wrap();
        test_zero_nij();
        test_reset_mid();
`ifdef SEQ_DRAIN_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_inst_seq.md
Name: core_inst_seq

Overview:
- Instruction sequencer that drives the 34-bit core instruction word plus the `mode` and `sel` side inputs.
- Replaces the testbench-driven instruction stream: walks every kernel position (kij) through the phases weight load, weight push, activation load, execute and output drain.
- During drain it writes psums into the ping-pong output SRAM banks, toggling the bank select per kij.
- Sits between a host/config register block and the core.

Parameters:
- ROW, 2, PE rows; weight words per kij.
- COL, 2, PE columns; extra cycles of weight push.
- ADDR_W, 11, xmem/pmem address width.
- KIJ_W, 4, width of the kernel-position count.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- start  in  1  one-cycle launch request
- num_kij  in  KIJ_W  kernel positions to run
- num_nij  in  ADDR_W  output pixels per kij
- w_base  in  ADDR_W  xmem base of weights; kij k uses w_base+k*ROW
- x_base  in  ADDR_W  xmem base of activations
- p_base  in  ADDR_W  pmem base of psums
- mode_in  in  1  0: 2-bit, 1: 4-bit; sampled at start
- ofifo_valid  in  1  core output FIFO has a row ready
- inst  out  34  core instruction word
- mode  out  1  registered copy of mode_in
- sel  out  1  pmem write bank for the current kij
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset is synchronous and active-high, on clock clk.
- All outputs are registered. Reset values:
  - inst = IDLE word 34'h1800C0000: CEN/WEN of pmem and xmem high (bits 32, 31, 19, 18), all other bits 0.
  - mode = 0, sel = 0, busy = 0, done = 0.
- inst fields:
  - [33] acc
  - [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
  - [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
  - [6] ofifo_rd, [5] 0, [4] sel copy
  - [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- FSM states: IDLE, WLD, WPUSH, ALD, EXEC, DRAIN, NEXT, FIN. Counters: k (kij), i (phase index), d (drained rows).
- IDLE:
  - start accepted only in IDLE; ignored while busy.
  - On accept: latch config, k=0, sel=0, busy=1.
  - If num_kij==0 or num_nij==0, go to FIN directly.
- inst is valid on the edge after the state is entered, so the first WLD word appears 1 cycle after start is sampled.
- WLD (ROW cycles):
  - CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k*ROW+i.
  - l0_wr is asserted one cycle after each read, to cover the 1-cycle SRAM read latency. Its last assertion overlaps the first WPUSH cycle.
- WPUSH (ROW+COL cycles): l0_rd=1, load=1.
- ALD (num_nij cycles): xmem read at x_base+i; l0_wr delayed one cycle as in WLD.
- EXEC (num_nij cycles): l0_rd=1, execute=1.
- DRAIN: stays until d==num_nij. In each cycle with ofifo_valid=1:
  - ofifo_rd=1
  - CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+d
  - acc=(k!=0)
  - d increments.
- DRAIN with ofifo_valid=0: ofifo_rd=0, pmem CEN/WEN high, A_pmem held.
- sel and inst[4] are held constant for the whole kij. The core adds its own pipeline delay to sel.
- NEXT (1 cycle): IDLE word; sel toggles, k increments; go to WLD if k<num_kij, else FIN.
- FIN (1 cycle): done=1, busy drops on the same edge, then IDLE.
- Address arithmetic wraps modulo 2^ADDR_W; no saturation.
- Mode: mode_in is latched only at start; later changes are ignored until the next start.
- Reset mid-operation: IDLE word on the next edge, counters cleared, no done pulse.

Optional Feature:
- Macro SEQ_DRAIN_TIMEOUT_EN.
- When defined:
  - An 8-bit watchdog counts consecutive DRAIN cycles with ofifo_valid=0.
  - At 255 the FSM enters ERR: IDLE word, output port `err`=1 sticky, busy held.
  - ERR is exited only by reset.
- When undefined: no `err` port; DRAIN waits indefinitely.

Decomposition:
- Package core_inst_pkg holds:
  - inst field bit positions
  - IDLE word constant
  - state enum
  - INST_W=34
- One combinational sub-module, core_inst_pack, assembles inst from named field signals. The FSM and counters stay in core_inst_seq.

Test Plan:
- Reset -> inst=34'h1800C0000, busy=0, done=0, sel=0; start held during reset -> ignored.
- start, num_kij=1, num_nij=4, w_base=0, x_base=16, p_base=100, ofifo_valid=1 -> xmem reads at 0,1 then l0_rd/load for 4 cycles, reads 16..19, execute for 4 cycles, pmem writes 100..103 with acc=0, sel=0, one done pulse.
- num_kij=3, num_nij=2 -> weight addresses 0/1, 2/3, 4/5; sel 0,1,0; acc 0,1,1 per kij.
- ofifo_valid toggling 1,0,0,1,1,0,1 in DRAIN -> ofifo_rd and pmem writes only in valid cycles; A_pmem 100,101,102,103 with no gaps.
- reset asserted mid-EXEC -> next edge inst=IDLE word, busy=0, no done; new start runs cleanly.
- num_nij=0 -> done 2 cycles after start, no xmem/pmem access; with SEQ_DRAIN_TIMEOUT_EN and ofifo_valid stuck 0 -> err=1 after 255 cycles.
